video_frame_streamer: RTL and testbench

//  Streams a fixed-point 2-D map (IMAGE_ROWS x IMAGE_COLUMNS) from a row-addressed memory as AXI4-Stream video.
//  One beat per pixel, raster order. tuser marks the first pixel of each frame; tlast marks the last pixel of each row.

---
 rtl/video_frame_streamer.sv | 245 ++++++++++++++++++++++++
 tb/tb_video_frame_streamer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_streamer.sv
// Streams a row-addressed fixed-point map as AXI4-Stream video (ternary colour or grayscale).
// Optional build macro VFS_TEST_PATTERN_EN adds pattern_i and an 8-bar colour test pattern.
module video_frame_streamer #(
  parameter int unsigned PIXEL_BITDEPTH        = 16,
  parameter int unsigned PIXEL_FRACTIONAL_SIZE = 8,
  parameter int unsigned IMAGE_COLUMNS         = 160,
  parameter int unsigned IMAGE_ROWS            = 160,
  localparam int unsigned ROW_W = (IMAGE_ROWS > 1) ? $clog2(IMAGE_ROWS) : 1,
  localparam int unsigned COL_W = (IMAGE_COLUMNS > 1) ? $clog2(IMAGE_COLUMNS) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    enable_i,
  input  logic                                    mode_i,
  input  logic [PIXEL_BITDEPTH-1:0]               thr_pos_i,
  input  logic [PIXEL_BITDEPTH-1:0]               thr_neg_i,
`ifdef VFS_TEST_PATTERN_EN
  input  logic                                    pattern_i,
`endif
  output logic [ROW_W-1:0]                        mem_read_address_o,
  input  logic [IMAGE_COLUMNS*PIXEL_BITDEPTH-1:0] mem_read_data_i,
  output logic                                    m00_axis_tvalid,
  output logic [31:0]                             m00_axis_tdata,
  output logic                                    m00_axis_tlast,
  output logic                                    m00_axis_tuser,
  input  logic                                    m00_axis_tready,
  output logic                                    busy_o,
  output logic [15:0]                             frame_count_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StStream, StRowEnd} state_e;

  localparam logic signed [PIXEL_BITDEPTH:0] GrayOffset = 128;

  state_e                            state_q, state_d;
  logic [ROW_W-1:0]                  row_q, row_d;
  logic [COL_W-1:0]                  col_q, col_d;
  logic                              tvalid_q, tvalid_d;
  logic [31:0]                       tdata_q, tdata_d;
  logic                              tlast_q, tlast_d;
  logic                              tuser_q, tuser_d;
  logic [15:0]                       frame_cnt_q, frame_cnt_d;
  logic                              mode_q, mode_d;
  logic [PIXEL_BITDEPTH-1:0]         thr_pos_q, thr_pos_d;
  logic [PIXEL_BITDEPTH-1:0]         thr_neg_q, thr_neg_d;

  logic                              load, last_col, last_row, first_px;
  logic signed [PIXEL_BITDEPTH-1:0]  pix, shifted, cfg_pos, cfg_neg;
  logic [PIXEL_BITDEPTH:0]           gsum;
  logic                              cfg_mode;
  logic [7:0]                        gray, red, grn, blu;
  logic [31:0]                       pixel_word;

`ifdef VFS_TEST_PATTERN_EN
  localparam int unsigned BarW  = (IMAGE_COLUMNS >= 8) ? IMAGE_COLUMNS / 8 : 1;
  localparam int unsigned BarCW = (BarW > 1) ? $clog2(BarW) : 1;
  logic             pattern_q, pattern_d, cfg_pat;
  logic [2:0]       bar_q, bar_d;
  logic [BarCW-1:0] bar_col_q, bar_col_d;
`endif

  // The output register may load whenever it is empty or its beat is being taken.
  assign load     = !tvalid_q || m00_axis_tready;
  assign last_col = (col_q == COL_W'(IMAGE_COLUMNS - 1));
  assign last_row = (row_q == ROW_W'(IMAGE_ROWS - 1));
  assign first_px = (row_q == '0) && (col_q == '0);

  always_comb begin
    pix = '0;
    for (int unsigned c = 0; c < IMAGE_COLUMNS; c++) begin
      if (col_q == COL_W'(c)) pix = mem_read_data_i[c*PIXEL_BITDEPTH +: PIXEL_BITDEPTH];
    end
  end

  // Frame configuration is live on the tuser beat and frozen for the rest of the frame.
  always_comb begin
    cfg_mode = first_px ? mode_i : mode_q;
    cfg_pos  = first_px ? thr_pos_i : thr_pos_q;
    cfg_neg  = first_px ? thr_neg_i : thr_neg_q;
    shifted  = pix >>> (PIXEL_FRACTIONAL_SIZE - 7);
    gsum     = {shifted[PIXEL_BITDEPTH-1], shifted} + GrayOffset;
    if (gsum[PIXEL_BITDEPTH]) begin
      gray = 8'h00;
    end else if (|gsum[PIXEL_BITDEPTH-1:8]) begin
      gray = 8'hFF;
    end else begin
      gray = gsum[7:0];
    end
    red = 8'h00;
    grn = 8'h00;
    blu = 8'h00;
    if (cfg_mode) begin
      red = gray;
      grn = gray;
      blu = gray;
    end else if (pix >= cfg_pos) begin
      red = 8'hFF;
      grn = 8'hFF;
      blu = 8'hFF;
    end else if (pix <= cfg_neg) begin
      blu = 8'hFF;
    end
`ifdef VFS_TEST_PATTERN_EN
    cfg_pat = first_px ? pattern_i : pattern_q;
    if (cfg_pat) begin
      red = bar_q[0] ? 8'hFF : 8'h00;
      grn = bar_q[1] ? 8'hFF : 8'h00;
      blu = bar_q[2] ? 8'hFF : 8'h00;
    end
`endif
    pixel_word = {2'b00, blu, 2'b00, grn, 2'b00, red, 2'b00};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_cnt_q <= '0;
      mode_q      <= 1'b0;
      thr_pos_q   <= '0;
      thr_neg_q   <= '0;
`ifdef VFS_TEST_PATTERN_EN
      pattern_q   <= 1'b0;
      bar_q       <= '0;
      bar_col_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      thr_pos_q   <= thr_pos_d;
      thr_neg_q   <= thr_neg_d;
`ifdef VFS_TEST_PATTERN_EN
      pattern_q   <= pattern_d;
      bar_q       <= bar_d;
      bar_col_q   <= bar_col_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable_i) state_d = StFetch;
      StFetch:  state_d = StStream;
      StStream: if (load && last_col) state_d = StRowEnd;
      // Leave only once the tlast beat has been taken.
      StRowEnd: if (load) state_d = (last_row && !enable_i) ? StIdle : StFetch;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    thr_pos_d   = thr_pos_q;
    thr_neg_d   = thr_neg_q;
`ifdef VFS_TEST_PATTERN_EN
    pattern_d   = pattern_q;
    bar_d       = bar_q;
    bar_col_d   = bar_col_q;
`endif
    if (load) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          row_d = '0;
          col_d = '0;
`ifdef VFS_TEST_PATTERN_EN
          bar_d     = '0;
          bar_col_d = '0;
`endif
        end
      end
      StStream: begin
        if (load) begin
          tvalid_d = 1'b1;
          tdata_d  = pixel_word;
          tlast_d  = last_col;
          tuser_d  = first_px;
          col_d    = last_col ? '0 : col_q + 1'b1;
          if (first_px) begin
            mode_d    = mode_i;
            thr_pos_d = thr_pos_i;
            thr_neg_d = thr_neg_i;
`ifdef VFS_TEST_PATTERN_EN
            pattern_d = pattern_i;
`endif
          end
`ifdef VFS_TEST_PATTERN_EN
          if (last_col) begin
            bar_d     = '0;
            bar_col_d = '0;
          end else if (bar_col_q == BarCW'(BarW - 1)) begin
            bar_d     = bar_q + 3'd1;
            bar_col_d = '0;
          end else begin
            bar_col_d = bar_col_q + 1'b1;
          end
`endif
        end
      end
      StRowEnd: begin
        if (load) begin
          row_d = last_row ? '0 : row_q + 1'b1;
          if (last_row) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_read_address_o = row_q;
    m00_axis_tvalid    = tvalid_q;
    m00_axis_tdata     = tdata_q;
    m00_axis_tlast     = tlast_q;
    m00_axis_tuser     = tuser_q;
    busy_o             = (state_q != StIdle);
    frame_count_o      = frame_cnt_q;
  end

endmodule

// File: tb/tb_video_frame_streamer.sv
// Directed bench for video_frame_streamer on a reduced 16x8 map with a 1-cycle-latency memory model.
module tb_video_frame_streamer;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int NPIX = COLS * ROWS;
  localparam logic [31:0] White = 32'h3FCF_F3FC;
  localparam logic [31:0] Blue  = 32'h3FC0_0000;

  logic               clk = 1'b0;
  logic               rst_n, enable, mode, tready, pattern;
  logic [15:0]        thr_pos, thr_neg;
  logic [2:0]         addr;
  logic [COLS*16-1:0] mem_rdata;
  logic               tvalid, tlast, tuser, busy;
  logic [31:0]        tdata;
  logic [15:0]        frame_count;

  logic [15:0] mem [ROWS][COLS];
  logic [33:0] beats [$];
  int          acc_cyc [$];
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_beat, cur;
  int          stab_err = 0;
  int          tests = 0;
  int          fails = 0;
  int          exp_frames = 0;

  always #5 clk = ~clk;

  video_frame_streamer #(
    .PIXEL_BITDEPTH       (16),
    .PIXEL_FRACTIONAL_SIZE(8),
    .IMAGE_COLUMNS        (COLS),
    .IMAGE_ROWS           (ROWS)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .enable_i          (enable),
    .mode_i            (mode),
    .thr_pos_i         (thr_pos),
    .thr_neg_i         (thr_neg),
`ifdef VFS_TEST_PATTERN_EN
    .pattern_i         (pattern),
`endif
    .mem_read_address_o(addr),
    .mem_read_data_i   (mem_rdata),
    .m00_axis_tvalid   (tvalid),
    .m00_axis_tdata    (tdata),
    .m00_axis_tlast    (tlast),
    .m00_axis_tuser    (tuser),
    .m00_axis_tready   (tready),
    .busy_o            (busy),
    .frame_count_o     (frame_count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < COLS; c++) mem_rdata[c*16 +: 16] <= mem[addr][c];
  end

  // Beat recorder and hold-while-stalled watcher.
  always @(negedge clk) begin
    cur = {tuser, tlast, tdata};
    if (prev_stall && (!tvalid || cur !== prev_beat)) stab_err++;
    if (tvalid && tready) begin
      beats.push_back(cur);
      acc_cyc.push_back(cyc);
    end
    prev_stall = tvalid && !tready;
    prev_beat  = cur;
  end

  function automatic logic [31:0] gray_word(input logic [7:0] g);
    return {2'b00, g, 2'b00, g, 2'b00, g, 2'b00};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mem[r][c] = v;
  endtask

  task automatic run_frame(input bit rnd, input bit mid, input logic mid_mode,
                           input logic [15:0] mid_pos, input logic [15:0] mid_neg,
                           output bit to);
    int n;
    to = 1'b0;
    beats.delete();
    acc_cyc.delete();
    enable = 1'b1;
    n = 0;
    while (!tvalid && n < 50) begin
      tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      step(1);
      n++;
    end
    if (n >= 50) to = 1'b1;
    enable = 1'b0;
    if (mid) begin
      mode    = mid_mode;
      thr_pos = mid_pos;
      thr_neg = mid_neg;
    end
    n = 0;
    while (busy && n < 3000) begin
      tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      step(1);
      n++;
    end
    if (n >= 3000) to = 1'b1;
    tready = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
    tests++; if (tdata !== 32'h0) begin fails++; $display("FAIL reset_tdata got=%h want=0", tdata); end
    tests++; if (addr !== 3'd0) begin fails++; $display("FAIL reset_addr got=%0d want=0", addr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_fcnt got=%0d want=0", frame_count); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_white_frame;
    int n, de, ue, le;
    fill_mem(16'h0100);
    mode = 1'b0; thr_pos = 16'h0040; thr_neg = 16'hFFC0; tready = 1'b1;
    beats.delete();
    enable = 1'b1;
    step(2);
    tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL latency_early tvalid got=%b want=0", tvalid); end
    step(1);
    tests++; if (tvalid !== 1'b1 || tuser !== 1'b1) begin
      fails++; $display("FAIL latency_first got tvalid=%b tuser=%b want 1/1", tvalid, tuser);
    end
    enable = 1'b0;
    n = 0;
    while (busy && n < 1000) begin step(1); n++; end
    step(1);
    exp_frames++;
    de = 0; ue = 0; le = 0;
    foreach (beats[i]) begin
      if (beats[i][31:0] !== White) de++;
      if (beats[i][33] !== (i == 0)) ue++;
      if (beats[i][32] !== (i % COLS == COLS - 1)) le++;
    end
    tests++; if (n >= 1000) begin fails++; $display("FAIL white_timeout busy still high"); end
    tests++; if (beats.size() != NPIX) begin fails++; $display("FAIL white_count got=%0d want=%0d", beats.size(), NPIX); end
    tests++; if (de != 0) begin fails++; $display("FAIL white_data bad beats=%0d want=0", de); end
    tests++; if (ue != 0) begin fails++; $display("FAIL white_tuser bad beats=%0d want=0", ue); end
    tests++; if (le != 0) begin fails++; $display("FAIL white_tlast bad beats=%0d want=0", le); end
    tests++; if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL white_fcnt got=%0d want=%0d", frame_count, exp_frames); end
    tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL white_idle_tvalid got=%b want=0", tvalid); end
  endtask

  task automatic test_backpressure;
    bit to;
    int de, ue, le;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mem[r][c] = 16'(2 * (r * COLS + c) - 256);
    mode = 1'b1;
    stab_err = 0;
    run_frame(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, to);
    exp_frames++;
    de = 0; ue = 0; le = 0;
    foreach (beats[i]) begin
      if (beats[i][31:0] !== gray_word(8'(i))) de++;
      if (beats[i][33] !== (i == 0)) ue++;
      if (beats[i][32] !== (i % COLS == COLS - 1)) le++;
    end
    tests++; if (to) begin fails++; $display("FAIL bp_timeout frame did not complete"); end
    tests++; if (beats.size() != NPIX) begin fails++; $display("FAIL bp_count got=%0d want=%0d", beats.size(), NPIX); end
    tests++; if (de != 0) begin fails++; $display("FAIL bp_data bad beats=%0d want=0", de); end
    tests++; if (ue + le != 0) begin fails++; $display("FAIL bp_flags bad=%0d want=0", ue + le); end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL bp_stable changes while stalled=%0d want=0", stab_err); end
    tests++; if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL bp_fcnt got=%0d want=%0d", frame_count, exp_frames); end
  endtask

  task automatic test_back_to_back;
    bit to;
    int de;
    run_frame(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, to);
    exp_frames++;
    de = 0;
    foreach (beats[i]) if (beats[i][31:0] !== gray_word(8'(i))) de++;
    tests++; if (to || beats.size() != NPIX || de != 0) begin
      fails++; $display("FAIL b2b_stream timeout=%0b count=%0d bad=%0d want 0/%0d/0", to, beats.size(), NPIX, de);
    end
    tests++; if (beats.size() == NPIX && acc_cyc[COLS] - acc_cyc[COLS-1] != 3) begin
      fails++; $display("FAIL b2b_row_gap got=%0d want=3", acc_cyc[COLS] - acc_cyc[COLS-1]);
    end
    tests++; if (beats.size() == NPIX && acc_cyc[NPIX-1] - acc_cyc[0] != (ROWS - 1) * (COLS + 2) + COLS - 1) begin
      fails++; $display("FAIL b2b_frame_span got=%0d want=%0d", acc_cyc[NPIX-1] - acc_cyc[0],
                        (ROWS - 1) * (COLS + 2) + COLS - 1);
    end
  endtask

  task automatic test_gray;
    bit to;
    logic [15:0] p [5];
    logic [7:0]  g [5];
    p = '{16'h0100, 16'h0000, 16'hFF00, 16'h7FFF, 16'h8000};
    g = '{8'hFF, 8'h80, 8'h00, 8'hFF, 8'h00};
    fill_mem(16'h0000);
    for (int k = 0; k < 5; k++) mem[0][k] = p[k];
    mode = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, to);
    exp_frames++;
    tests++; if (to || beats.size() != NPIX) begin fails++; $display("FAIL gray_count got=%0d want=%0d", beats.size(), NPIX); end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (beats.size() > k && beats[k][31:0] !== gray_word(g[k])) begin
        fails++; $display("FAIL gray_px%0d got=%h want=%h", k, beats[k][31:0], gray_word(g[k]));
      end
    end
  endtask

  task automatic test_ternary;
    bit to;
    logic [31:0] e1 [6];
    fill_mem(16'h0000);
    mem[0][0] = 16'h0040; mem[0][1] = 16'h003F; mem[0][2] = 16'hFFC0;
    mem[0][3] = 16'hFFC1; mem[0][4] = 16'hFFBF; mem[0][5] = 16'h0008;
    mem[ROWS-1][0] = 16'h0040;
    mode = 1'b0; thr_pos = 16'h0040; thr_neg = 16'hFFC0;
    // Mid-frame change must not reach this frame.
    run_frame(1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h8000, to);
    exp_frames++;
    e1 = '{White, 32'h0, Blue, 32'h0, Blue, 32'h0};
    tests++; if (to || beats.size() != NPIX) begin fails++; $display("FAIL tern_count got=%0d want=%0d", beats.size(), NPIX); end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (beats.size() > k && beats[k][31:0] !== e1[k]) begin
        fails++; $display("FAIL tern_px%0d got=%h want=%h", k, beats[k][31:0], e1[k]);
      end
    end
    tests++; if (beats.size() == NPIX && (beats[NPIX-COLS][31:0] !== White || beats[NPIX-COLS+1][31:0] !== 32'h0)) begin
      fails++; $display("FAIL tern_held got=%h,%h want=%h,0", beats[NPIX-COLS][31:0], beats[NPIX-COLS+1][31:0], White);
    end
    run_frame(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, to);
    exp_frames++;
    tests++; if (beats.size() != NPIX || beats[0][31:0] !== gray_word(8'hA0) || beats[1][31:0] !== gray_word(8'h9F)) begin
      fails++; $display("FAIL tern_next_frame got=%h,%h want=%h,%h", beats[0][31:0], beats[1][31:0],
                        gray_word(8'hA0), gray_word(8'h9F));
    end
    mode = 1'b0; thr_pos = 16'h0000; thr_neg = 16'h0010;
    run_frame(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, to);
    exp_frames++;
    tests++; if (beats.size() != NPIX || beats[2][31:0] !== Blue || beats[5][31:0] !== White || beats[6][31:0] !== White) begin
      fails++; $display("FAIL tern_overlap got=%h,%h,%h want=%h,%h,%h", beats[2][31:0], beats[5][31:0],
                        beats[6][31:0], Blue, White, White);
    end
    thr_pos = 16'h0040; thr_neg = 16'hFFC0;
  endtask

  task automatic test_enable_stop;
    int n;
    beats.delete();
    enable = 1'b1;
    n = 0;
    while (addr !== 3'd4 && n < 500) begin step(1); n++; end
    enable = 1'b0;
    while (busy && n < 1500) begin step(1); n++; end
    step(1);
    exp_frames++;
    tests++; if (n >= 1500) begin fails++; $display("FAIL stop_timeout waited=%0d", n); end
    tests++; if (beats.size() != NPIX || beats[NPIX-1][32] !== 1'b1) begin
      fails++; $display("FAIL stop_complete got count=%0d want=%0d with final tlast", beats.size(), NPIX);
    end
    tests++; if (busy !== 1'b0 || tvalid !== 1'b0) begin fails++; $display("FAIL stop_idle got busy=%b tvalid=%b want 0/0", busy, tvalid); end
    tests++; if (frame_count !== 16'(exp_frames)) begin fails++; $display("FAIL stop_fcnt got=%0d want=%0d", frame_count, exp_frames); end
  endtask

  task automatic test_sync_reset;
    int n;
    beats.delete();
    enable = 1'b1;
    n = 0;
    while (beats.size() < 20 && n < 200) begin step(1); n++; end
    rst_n = 1'b0;
    step(1);
    exp_frames = 0;
    tests++; if ({tvalid, tlast, tuser} !== 3'b000 || tdata !== 32'h0) begin
      fails++; $display("FAIL rst_mid_outputs got v=%b l=%b u=%b d=%h want all 0", tvalid, tlast, tuser, tdata);
    end
    tests++; if (addr !== 3'd0 || busy !== 1'b0 || frame_count !== 16'd0) begin
      fails++; $display("FAIL rst_mid_state got addr=%0d busy=%b fcnt=%0d want 0/0/0", addr, busy, frame_count);
    end
    rst_n = 1'b1;
    beats.delete();
    n = 0;
    while (beats.size() < 1 && n < 50) begin step(1); n++; end
    tests++; if (beats.size() < 1 || beats[0][33] !== 1'b1) begin fails++; $display("FAIL rst_restart_tuser got count=%0d want first beat with tuser", beats.size()); end
    enable = 1'b0;
    n = 0;
    while (busy && n < 1000) begin step(1); n++; end
    step(1);
    exp_frames++;
    tests++; if (beats.size() != NPIX || frame_count !== 16'(exp_frames)) begin
      fails++; $display("FAIL rst_restart_frame got count=%0d fcnt=%0d want %0d/%0d", beats.size(), frame_count, NPIX, exp_frames);
    end
  endtask

`ifdef VFS_TEST_PATTERN_EN
  task automatic test_pattern;
    bit to;
    fill_mem(16'h0000);
    mode = 1'b0; pattern = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, to);
    pattern = 1'b0;
    tests++; if (beats.size() != NPIX || beats[0][31:0] !== 32'h0 || beats[1][31:0] !== 32'h0) begin
      fails++; $display("FAIL pat_bar0 got=%h,%h want=0,0", beats[0][31:0], beats[1][31:0]);
    end
    tests++; if (beats[2][31:0] !== 32'h0000_03FC || beats[4][31:0] !== 32'h000F_F000) begin
      fails++; $display("FAIL pat_bar12 got=%h,%h want=000003fc,000ff000", beats[2][31:0], beats[4][31:0]);
    end
    tests++; if (beats[COLS-2][31:0] !== White || beats[COLS-1][31:0] !== White) begin
      fails++; $display("FAIL pat_bar7 got=%h,%h want=%h", beats[COLS-2][31:0], beats[COLS-1][31:0], White);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; tready = 1'b1; pattern = 1'b0;
    thr_pos = 16'h0040; thr_neg = 16'hFFC0;
    fill_mem(16'h0000);
    test_reset();
    test_white_frame();
    test_backpressure();
    test_back_to_back();
    test_gray();
    test_ternary();
    test_enable_stop();
    test_sync_reset();
`ifdef VFS_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
